quad_gate_test_sequencer: RTL and testbench



---
 rtl/quad_gate_test_sequencer_pkg.sv | 30 +++
 rtl/quad_gate_test_sequencer_if.sv | 44 ++++
 rtl/quad_gate_test_sequencer_gate_ref_fn.sv | 25 ++
 rtl/quad_gate_test_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_quad_gate_test_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/quad_gate_test_sequencer_pkg.sv
// quad_gate_pkg: shared encodings, state enum and drive helper for the
// quad 2-input gate test sequencer and the benches that reuse it.
package quad_gate_pkg;

  localparam int NUM_GATES = 4;
  localparam int NUM_VEC   = 4;

  // Gate function encodings; anything at or above FN_RESERVED_MIN is unused.
  localparam logic [2:0] FN_AND          = 3'd0;
  localparam logic [2:0] FN_OR           = 3'd1;
  localparam logic [2:0] FN_NAND         = 3'd2;
  localparam logic [2:0] FN_NOR          = 3'd3;
  localparam logic [2:0] FN_XOR          = 3'd4;
  localparam logic [2:0] FN_RESERVED_MIN = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Drive one operand: only the active gate's lane carries the bit,
  // idle lanes are held at 0.
  function automatic logic [NUM_GATES-1:0] lane_drive(input logic [1:0] gate,
                                                      input logic       bit_val);
    return (4'b0001 << gate) & {NUM_GATES{bit_val}};
  endfunction

endpackage

// File: rtl/quad_gate_test_sequencer_if.sv
// Interface bundling the sequencer's control/status and the DUT pin bus.
// Optional first-fail capture signals exist only when
// QUAD_GATE_SEQ_FIRST_FAIL_EN is defined.
interface quad_gate_test_sequencer_if;
  import quad_gate_pkg::*;

  logic                 start;
  logic [2:0]           func;
  logic [NUM_GATES-1:0] y_i;
  logic [NUM_GATES-1:0] a_o;
  logic [NUM_GATES-1:0] b_o;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_GATES-1:0] fail_mask;
  logic [4:0]           err_cnt;
`ifdef QUAD_GATE_SEQ_FIRST_FAIL_EN
  logic                 first_fail_valid;
  logic [1:0]           first_fail_gate;
  logic [1:0]           first_fail_vec;
  logic [NUM_GATES-1:0] first_fail_y;

  modport master (
    input  start, func, y_i,
    output a_o, b_o, busy, done, pass, fail_mask, err_cnt,
           first_fail_valid, first_fail_gate, first_fail_vec, first_fail_y
  );
  modport slave (
    output start, func, y_i,
    input  a_o, b_o, busy, done, pass, fail_mask, err_cnt,
           first_fail_valid, first_fail_gate, first_fail_vec, first_fail_y
  );
`else
  modport master (
    input  start, func, y_i,
    output a_o, b_o, busy, done, pass, fail_mask, err_cnt
  );
  modport slave (
    output start, func, y_i,
    input  a_o, b_o, busy, done, pass, fail_mask, err_cnt
  );
`endif

endinterface

// File: rtl/quad_gate_test_sequencer_gate_ref_fn.sv
// gate_ref_fn: combinational reference for the four lanes of a quad
// 2-input gate part; reserved encodings return 0.
module gate_ref_fn
  import quad_gate_pkg::*;
(
  input  logic [2:0]           func,
  input  logic [NUM_GATES-1:0] a,
  input  logic [NUM_GATES-1:0] b,
  output logic [NUM_GATES-1:0] y
);

  // Expected Y for every lane under the selected function
  always_comb begin
    y = 4'h0;
    case (func)
      FN_AND:  y = a & b;
      FN_OR:   y = a | b;
      FN_NAND: y = ~(a & b);
      FN_NOR:  y = ~(a | b);
      FN_XOR:  y = a ^ b;
      default: y = 4'h0;
    endcase
  end

endmodule

// File: rtl/quad_gate_test_sequencer.sv
// quad_gate_test_sequencer: walks all four gates of a quad 2-input part
// through their truth tables, waits SETTLE_CYCLES+1 cycles per vector and
// checks every Y output (idle lanes must show f(0,0)).
// Optional macro QUAD_GATE_SEQ_FIRST_FAIL_EN adds first-mismatch capture.
module quad_gate_test_sequencer
  import quad_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                        clk,
  input logic                        rst,
  quad_gate_test_sequencer_if.master bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [3:0] LAST_IDX    = 4'(NUM_GATES * NUM_VEC - 1);

  state_t               state_r, state_s;
  logic [2:0]           func_r, func_s;
  logic [3:0]           idx_r, idx_s;      // {gate, vec}
  logic [7:0]           cnt_r, cnt_s;
  logic [NUM_GATES-1:0] a_r, a_s, b_r, b_s;
  logic                 busy_r, busy_s, done_r, done_s, pass_r, pass_s;
  logic [NUM_GATES-1:0] fail_mask_r, fail_mask_s;
  logic [4:0]           err_cnt_r, err_cnt_s;

  logic [NUM_GATES-1:0] exp_y_s, mismatch_s, fail_mask_upd_s;
  logic [4:0]           err_cnt_upd_s;
  logic [3:0]           idx_inc_s;
  logic                 accept_s;

  // a_r/b_r already hold zeros on idle lanes, so the reference sees f(0,0) there
  gate_ref_fn u_ref (.func(func_r), .a(a_r), .b(b_r), .y(exp_y_s));

  assign mismatch_s      = exp_y_s ^ bus.y_i;
  assign fail_mask_upd_s = fail_mask_r | mismatch_s;
  assign err_cnt_upd_s   = err_cnt_r + {4'd0, |mismatch_s};
  assign idx_inc_s       = idx_r + 4'd1;
  assign accept_s        = (state_r == ST_IDLE) && bus.start;

  // Next-state and next-output logic for the sequencer FSM
  always_comb begin
    state_s     = state_r;
    func_s      = func_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    a_s         = a_r;
    b_s         = b_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    pass_s      = pass_r;
    fail_mask_s = fail_mask_r;
    err_cnt_s   = err_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          func_s      = bus.func;
          idx_s       = 4'd0;
          cnt_s       = 8'd0;
          pass_s      = 1'b0;
          err_cnt_s   = 5'd0;
          if (bus.func >= FN_RESERVED_MIN) begin
            fail_mask_s = 4'hF;
            done_s      = 1'b1;
            state_s     = ST_DONE;
          end else begin
            fail_mask_s = 4'h0;
            busy_s      = 1'b1;
            a_s         = lane_drive(2'd0, 1'b0);
            b_s         = lane_drive(2'd0, 1'b0);
            state_s     = ST_SETTLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_s   = 8'd0;
          state_s = ST_CHECK;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_CHECK: begin
        fail_mask_s = fail_mask_upd_s;
        err_cnt_s   = err_cnt_upd_s;
        if (idx_r == LAST_IDX) begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_cnt_upd_s == 5'd0);
          a_s     = 4'h0;
          b_s     = 4'h0;
          state_s = ST_DONE;
        end else begin
          idx_s   = idx_inc_s;
          a_s     = lane_drive(idx_inc_s[3:2], idx_inc_s[1]);
          b_s     = lane_drive(idx_inc_s[3:2], idx_inc_s[0]);
          state_s = ST_SETTLE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State and output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      func_r      <= 3'd0;
      idx_r       <= 4'd0;
      cnt_r       <= 8'd0;
      a_r         <= 4'h0;
      b_r         <= 4'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_mask_r <= 4'h0;
      err_cnt_r   <= 5'd0;
    end else begin
      state_r     <= state_s;
      func_r      <= func_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      a_r         <= a_s;
      b_r         <= b_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_mask_r <= fail_mask_s;
      err_cnt_r   <= err_cnt_s;
    end
  end

  assign bus.a_o       = a_r;
  assign bus.b_o       = b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.fail_mask = fail_mask_r;
  assign bus.err_cnt   = err_cnt_r;

`ifdef QUAD_GATE_SEQ_FIRST_FAIL_EN
  logic                 ff_valid_r, ff_valid_s;
  logic [1:0]           ff_gate_r, ff_gate_s, ff_vec_r, ff_vec_s;
  logic [NUM_GATES-1:0] ff_y_r, ff_y_s;

  // Capture gate, vector and raw Y of the first mismatching check of a run
  always_comb begin
    ff_valid_s = ff_valid_r;
    ff_gate_s  = ff_gate_r;
    ff_vec_s   = ff_vec_r;
    ff_y_s     = ff_y_r;
    if (accept_s) begin
      ff_valid_s = 1'b0;
      ff_gate_s  = 2'd0;
      ff_vec_s   = 2'd0;
      ff_y_s     = 4'h0;
    end else if ((state_r == ST_CHECK) && (|mismatch_s) && !ff_valid_r) begin
      ff_valid_s = 1'b1;
      ff_gate_s  = idx_r[3:2];
      ff_vec_s   = idx_r[1:0];
      ff_y_s     = bus.y_i;
    end else begin
      ff_valid_s = ff_valid_r;
    end
  end

  // First-fail capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_valid_r <= 1'b0;
      ff_gate_r  <= 2'd0;
      ff_vec_r   <= 2'd0;
      ff_y_r     <= 4'h0;
    end else begin
      ff_valid_r <= ff_valid_s;
      ff_gate_r  <= ff_gate_s;
      ff_vec_r   <= ff_vec_s;
      ff_y_r     <= ff_y_s;
    end
  end

  assign bus.first_fail_valid = ff_valid_r;
  assign bus.first_fail_gate  = ff_gate_r;
  assign bus.first_fail_vec   = ff_vec_r;
  assign bus.first_fail_y     = ff_y_r;
`endif

endmodule

// File: tb/tb_quad_gate_test_sequencer.sv
// Directed self-checking bench for quad_gate_test_sequencer (SETTLE_CYCLES=2).
// A behavioural quad gate model with optional stuck-at-0 outputs sits on y_i.
module tb_quad_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_gate_test_sequencer_if bus ();

  quad_gate_test_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0] model_func;
  logic [3:0] stuck0;

  function automatic logic [3:0] gate_model(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      default: return 4'h0;
    endcase
  endfunction

  assign bus.y_i = gate_model(model_func, bus.a_o, bus.b_o) & ~stuck0;

  int n_pass = 0;
  int n_total = 0;

  int done_first, done_cnt, busy_cnt, seq_bad, ab_nonzero;

  // Start a run and observe 80 cycles; cycle 1 is the one right after the start edge.
  task automatic run_seq(input logic [2:0] fn, input int restart_at, input int rst_at);
    int v;
    logic [3:0] vv, ea, eb;
    bus.func  = fn;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_first = 0; done_cnt = 0; busy_cnt = 0; seq_bad = 0; ab_nonzero = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_first == 0) done_first = cyc;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.a_o !== 4'h0 || bus.b_o !== 4'h0) ab_nonzero++;
      if (fn < 3'd5 && rst_at == 0) begin
        if (cyc <= 64) begin
          v  = (cyc - 1) / 4;
          vv = v[3:0];
          ea = (4'b0001 << vv[3:2]) & {4{vv[1]}};
          eb = (4'b0001 << vv[3:2]) & {4{vv[0]}};
        end else begin
          ea = 4'h0;
          eb = 4'h0;
        end
        if (bus.a_o !== ea || bus.b_o !== eb) seq_bad++;
      end
      bus.start = (cyc == restart_at);
      if (rst_at != 0 && cyc == rst_at) rst = 1'b1;
      if (rst_at != 0 && cyc == rst_at + 1) begin
        n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %0b exp 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL midrst_done got %0b exp 0", bus.done); else n_pass++;
        n_total++; if (bus.pass !== 1'b0) $display("FAIL midrst_pass got %0b exp 0", bus.pass); else n_pass++;
        n_total++; if (bus.fail_mask !== 4'h0) $display("FAIL midrst_mask got %h exp 0", bus.fail_mask); else n_pass++;
        n_total++; if (bus.err_cnt !== 5'd0) $display("FAIL midrst_err got %0d exp 0", bus.err_cnt); else n_pass++;
        n_total++; if (bus.a_o !== 4'h0 || bus.b_o !== 4'h0) $display("FAIL midrst_ab got a=%h b=%h exp 0/0", bus.a_o, bus.b_o); else n_pass++;
        rst = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.func = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL rst_done got %0b exp 0", bus.done); else n_pass++;
    n_total++; if (bus.pass !== 1'b0) $display("FAIL rst_pass got %0b exp 0", bus.pass); else n_pass++;
    n_total++; if (bus.fail_mask !== 4'h0) $display("FAIL rst_mask got %h exp 0", bus.fail_mask); else n_pass++;
    n_total++; if (bus.err_cnt !== 5'd0) $display("FAIL rst_err got %0d exp 0", bus.err_cnt); else n_pass++;
    n_total++; if (bus.a_o !== 4'h0 || bus.b_o !== 4'h0) $display("FAIL rst_ab got a=%h b=%h exp 0/0", bus.a_o, bus.b_o); else n_pass++;
`ifdef QUAD_GATE_SEQ_FIRST_FAIL_EN
    n_total++; if (bus.first_fail_valid !== 1'b0) $display("FAIL rst_ffv got %0b exp 0", bus.first_fail_valid); else n_pass++;
`endif
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_start_dropped got busy=%0b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_and_clean(input string tag);
    model_func = 3'd0; stuck0 = 4'h0;
    run_seq(3'd0, 0, 0);
    n_total++; if (done_first != 65) $display("FAIL %s_done_cycle got %0d exp 65", tag, done_first); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL %s_done_count got %0d exp 1", tag, done_cnt); else n_pass++;
    n_total++; if (busy_cnt != 64) $display("FAIL %s_busy_cycles got %0d exp 64", tag, busy_cnt); else n_pass++;
    n_total++; if (seq_bad != 0) $display("FAIL %s_vec_sequence got %0d bad cycles exp 0", tag, seq_bad); else n_pass++;
    n_total++; if (bus.pass !== 1'b1) $display("FAIL %s_pass got %0b exp 1", tag, bus.pass); else n_pass++;
    n_total++; if (bus.fail_mask !== 4'h0) $display("FAIL %s_mask got %h exp 0", tag, bus.fail_mask); else n_pass++;
    n_total++; if (bus.err_cnt !== 5'd0) $display("FAIL %s_err got %0d exp 0", tag, bus.err_cnt); else n_pass++;
  endtask

  task automatic test_stuck_y3();
    model_func = 3'd0; stuck0 = 4'b0100;
    run_seq(3'd0, 0, 0);
    n_total++; if (done_first != 65) $display("FAIL stuck_done_cycle got %0d exp 65", done_first); else n_pass++;
    n_total++; if (bus.pass !== 1'b0) $display("FAIL stuck_pass got %0b exp 0", bus.pass); else n_pass++;
    n_total++; if (bus.fail_mask !== 4'b0100) $display("FAIL stuck_mask got %b exp 0100", bus.fail_mask); else n_pass++;
    n_total++; if (bus.err_cnt !== 5'd1) $display("FAIL stuck_err got %0d exp 1", bus.err_cnt); else n_pass++;
`ifdef QUAD_GATE_SEQ_FIRST_FAIL_EN
    n_total++; if (bus.first_fail_valid !== 1'b1) $display("FAIL stuck_ffv got %0b exp 1", bus.first_fail_valid); else n_pass++;
    n_total++; if (bus.first_fail_gate !== 2'd2) $display("FAIL stuck_ffgate got %0d exp 2", bus.first_fail_gate); else n_pass++;
    n_total++; if (bus.first_fail_vec !== 2'd3) $display("FAIL stuck_ffvec got %0d exp 3", bus.first_fail_vec); else n_pass++;
    n_total++; if (bus.first_fail_y !== 4'h0) $display("FAIL stuck_ffy got %h exp 0", bus.first_fail_y); else n_pass++;
`endif
    stuck0 = 4'h0;
  endtask

  task automatic test_nand_on_and();
    model_func = 3'd0; stuck0 = 4'h0;
    run_seq(3'd2, 0, 0);
    n_total++; if (done_first != 65) $display("FAIL nand_done_cycle got %0d exp 65", done_first); else n_pass++;
    n_total++; if (bus.pass !== 1'b0) $display("FAIL nand_pass got %0b exp 0", bus.pass); else n_pass++;
    n_total++; if (bus.fail_mask !== 4'hF) $display("FAIL nand_mask got %h exp F", bus.fail_mask); else n_pass++;
    n_total++; if (bus.err_cnt !== 5'd16) $display("FAIL nand_err got %0d exp 16", bus.err_cnt); else n_pass++;
`ifdef QUAD_GATE_SEQ_FIRST_FAIL_EN
    n_total++; if (bus.first_fail_gate !== 2'd0 || bus.first_fail_vec !== 2'd0) $display("FAIL nand_ffpos got g=%0d v=%0d exp 0/0", bus.first_fail_gate, bus.first_fail_vec); else n_pass++;
`endif
  endtask

  task automatic test_other_funcs();
    logic [2:0] fns [3] = '{3'd1, 3'd3, 3'd4};
    for (int i = 0; i < 3; i++) begin
      model_func = fns[i]; stuck0 = 4'h0;
      run_seq(fns[i], 0, 0);
      n_total++; if (bus.pass !== 1'b1 || bus.err_cnt !== 5'd0) $display("FAIL func%0d_clean got pass=%0b err=%0d exp 1/0", fns[i], bus.pass, bus.err_cnt); else n_pass++;
      n_total++; if (done_first != 65 || seq_bad != 0) $display("FAIL func%0d_timing got done=%0d bad=%0d exp 65/0", fns[i], done_first, seq_bad); else n_pass++;
    end
    model_func = 3'd0;
  endtask

  task automatic test_reserved();
    model_func = 3'd0; stuck0 = 4'h0;
    run_seq(3'd6, 0, 0);
    n_total++; if (done_first != 1 || done_cnt != 1) $display("FAIL rsv_done got first=%0d count=%0d exp 1/1", done_first, done_cnt); else n_pass++;
    n_total++; if (busy_cnt != 0) $display("FAIL rsv_busy got %0d cycles exp 0", busy_cnt); else n_pass++;
    n_total++; if (ab_nonzero != 0) $display("FAIL rsv_ab got %0d driven cycles exp 0", ab_nonzero); else n_pass++;
    n_total++; if (bus.pass !== 1'b0) $display("FAIL rsv_pass got %0b exp 0", bus.pass); else n_pass++;
    n_total++; if (bus.fail_mask !== 4'hF) $display("FAIL rsv_mask got %h exp F", bus.fail_mask); else n_pass++;
    n_total++; if (bus.err_cnt !== 5'd0) $display("FAIL rsv_err got %0d exp 0", bus.err_cnt); else n_pass++;
`ifdef QUAD_GATE_SEQ_FIRST_FAIL_EN
    n_total++; if (bus.first_fail_valid !== 1'b0) $display("FAIL rsv_ffv got %0b exp 0", bus.first_fail_valid); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    model_func = 3'd0; stuck0 = 4'h0;
    run_seq(3'd0, 10, 0);
    n_total++; if (done_first != 65 || done_cnt != 1) $display("FAIL b2b_busy_start got first=%0d count=%0d exp 65/1", done_first, done_cnt); else n_pass++;
    n_total++; if (busy_cnt != 64 || seq_bad != 0) $display("FAIL b2b_busy_seq got busy=%0d bad=%0d exp 64/0", busy_cnt, seq_bad); else n_pass++;
    run_seq(3'd0, 65, 0);
    n_total++; if (done_cnt != 1 || busy_cnt != 64) $display("FAIL b2b_done_start got count=%0d busy=%0d exp 1/64", done_cnt, busy_cnt); else n_pass++;
    n_total++; if (bus.pass !== 1'b1) $display("FAIL b2b_pass got %0b exp 1", bus.pass); else n_pass++;
  endtask

  task automatic test_mid_reset();
    model_func = 3'd0; stuck0 = 4'h0;
    run_seq(3'd2, 0, 30);
    n_total++; if (done_cnt != 0) $display("FAIL midrst_no_done got %0d pulses exp 0", done_cnt); else n_pass++;
    n_total++; if (busy_cnt != 30) $display("FAIL midrst_busy_cycles got %0d exp 30", busy_cnt); else n_pass++;
    test_and_clean("after_rst");
  endtask

  initial begin
    model_func = 3'd0;
    stuck0     = 4'h0;
    bus.start  = 1'b0;
    bus.func   = 3'd0;
    test_reset();
    test_and_clean("and");
    test_stuck_y3();
    test_nand_on_and();
    test_other_funcs();
    test_reserved();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
